mux_4to1_1_st: RTL and testbench

Single-bit 4-to-1 multiplexer with a zero-latency combinational output and an optional registered copy of the selection. It steers one of four 1-bit sources (`a`, `b`, `c`, `d`) to `out` under a 2-bit `select`. It uses a non-binary-ordered select map. The registered side (`out_q`, `sel_q`, `changed`, `rise_cnt`) lets clocked consumers sample the mux result and the select history without extra glue logic.

---
 rtl/mux_4to1_1_st.sv | 84 ++++++++
 tb/tb_mux_4to1_1_st.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_1_st.sv
`default_nettype none
// ============================================================================
// Module      : mux_4to1_1_st
// Description : 1-bit 4:1 mux (select map 00->d, 01->b, 10->c, 11->a) with a
//               registered copy, select-change strobe and rising-edge counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4to1_1_st #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic [1:0]       select,
  input  logic             en,
  output logic             out,
  output logic             out_q,
  output logic [1:0]       sel_q,
  output logic             changed,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic             w_out;
  logic             w_rise;
  logic             r_out_q;
  logic             r_out_q_d;
  logic [1:0]       r_sel_q;
  logic             r_changed;
  logic [CNT_W-1:0] r_rise_cnt;

  // An unknown select propagates as X rather than falling back to a source.
  always_comb begin
    w_out = 1'bx;
    case (select)
      2'b00:   w_out = d;
      2'b01:   w_out = b;
      2'b10:   w_out = c;
      2'b11:   w_out = a;
      default: w_out = 1'bx;
    endcase
  end

  assign w_rise = r_out_q & ~r_out_q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q   <= 1'b0;
      r_sel_q   <= 2'b00;
      r_changed <= 1'b0;
    end else if (en) begin
      r_out_q   <= w_out;
      r_sel_q   <= select;
      r_changed <= (select != r_sel_q);
    end else begin
      r_changed <= 1'b0;
    end
  end

  // Edge detection runs one cycle behind out_q, so the count lands on the
  // edge after out_q rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q_d  <= 1'b0;
      r_rise_cnt <= '0;
    end else begin
      r_out_q_d <= r_out_q;
      if (w_rise && (r_rise_cnt != c_CNT_MAX))
        r_rise_cnt <= r_rise_cnt + CNT_W'(1);
    end
  end

  assign out      = w_out;
  assign out_q    = r_out_q;
  assign sel_q    = r_sel_q;
  assign changed  = r_changed;
  assign rise_cnt = r_rise_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1_1_st.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4to1_1_st
// Description : Directed self-checking bench for mux_4to1_1_st (CNT_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4to1_1_st;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             clk_run = 1'b0;
  logic             rst;
  logic             a, b, c, d;
  logic [1:0]       select;
  logic             en;
  logic             out;
  logic             out_q;
  logic [1:0]       sel_q;
  logic             changed;
  logic [CNT_W-1:0] rise_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mux_4to1_1_st #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .select   (select),
    .en       (en),
    .out      (out),
    .out_q    (out_q),
    .sel_q    (sel_q),
    .changed  (changed),
    .rise_cnt (rise_cnt)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic e_out_q, input logic [1:0] e_sel_q,
                            input logic e_changed);
    check({tag, ".out_q"},   {31'd0, out_q},   {31'd0, e_out_q});
    check({tag, ".sel_q"},   {30'd0, sel_q},   {30'd0, e_sel_q});
    check({tag, ".changed"}, {31'd0, changed}, {31'd0, e_changed});
  endtask

  // Drive select on the falling edge, then sample 1 unit after the rising edge.
  task automatic step(input logic [1:0] s);
    @(negedge clk);
    select = s;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [1:0] idx);
    {a, b, c, d} = 4'b0000;
    case (idx)
      2'd0: d = 1'b1;
      2'd1: b = 1'b1;
      2'd2: c = 1'b1;
      default: a = 1'b1;
    endcase
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; select = 2'b00;
    {a, b, c, d} = 4'b0000;
    #10;
    check("reset.out", {31'd0, out}, 32'd0);
    check_regs("reset", 1'b0, 2'b00, 1'b0);
    check("reset.rise_cnt", {30'd0, rise_cnt}, 32'd0);
    rst = 1'b0;

    // Combinational path with no clock running.
    d = 1'b1; #10;
    check("comb.d", {31'd0, out}, 32'd1);
    a = 1'b1; b = 1'b1; c = 1'b1; #10;
    check("comb.d_abc1", {31'd0, out}, 32'd1);
    a = 1'b0; b = 1'b0; c = 1'b0; #10;
    check("comb.d_abc0", {31'd0, out}, 32'd1);
    {a, b, c, d} = 4'b0100; select = 2'b01; #10;
    check("comb.b", {31'd0, out}, 32'd1);
    {a, b, c, d} = 4'b0010; select = 2'b10; #10;
    check("comb.c", {31'd0, out}, 32'd1);
    {a, b, c, d} = 4'b1000; select = 2'b11; #10;
    check("comb.a", {31'd0, out}, 32'd1);

    // Only a non-selected source high: out must be 0 (12 cases).
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (i != s) begin
          select = 2'(s);
          set_src(2'(i));
          #10;
          check($sformatf("excl.sel%0d_src%0d", s, i), {31'd0, out}, 32'd0);
        end
      end
    end

    // Registered path: d=1, b=0, c=1, a=0.
    {a, b, c, d} = 4'b0011;
    select = 2'b00; en = 1'b1;
    rst = 1'b1; #2; rst = 1'b0;
    clk_run = 1'b1;
    step(2'b00); check_regs("reg1", 1'b1, 2'b00, 1'b0);
    step(2'b01); check_regs("reg2", 1'b0, 2'b01, 1'b1);
    step(2'b01); check_regs("reg3", 1'b0, 2'b01, 1'b0);
    step(2'b10); check_regs("reg4", 1'b1, 2'b10, 1'b1);

    // Enable hold: registers freeze while out keeps following.
    @(negedge clk);
    en = 1'b0; select = 2'b11; a = 1'b0;
    #1;
    check("hold.out_comb", {31'd0, out}, 32'd0);
    @(posedge clk); #1;
    check_regs("hold1", 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    select = 2'b01; b = 1'b1;
    #1;
    check("hold.out_comb2", {31'd0, out}, 32'd1);
    @(posedge clk); #1;
    check_regs("hold2", 1'b1, 2'b10, 1'b0);

    // Counter saturation: toggle d with select=00; out_q rises on edges 1,3,5,7,9.
    #2; rst = 1'b1; #1;
    check_regs("rst_mid", 1'b0, 2'b00, 1'b0);
    check("rst_mid.rise_cnt", {30'd0, rise_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; select = 2'b00; {a, b, c} = 3'b000; d = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      d = (e % 2 == 1);
      @(posedge clk); #1;
      if (e == 2)  check("cnt.e2",  {30'd0, rise_cnt}, 32'd1);
      if (e == 4)  check("cnt.e4",  {30'd0, rise_cnt}, 32'd2);
      if (e == 6)  check("cnt.e6",  {30'd0, rise_cnt}, 32'd3);
      if (e == 8)  check("cnt.e8",  {30'd0, rise_cnt}, 32'd3);
      if (e == 10) check("cnt.e10", {30'd0, rise_cnt}, 32'd3);
    end

    // Reset drops an in-flight changed pulse and the count; out unaffected.
    @(negedge clk);
    b = 1'b1; select = 2'b01;
    @(posedge clk); #1;
    check("pulse.changed", {31'd0, changed}, 32'd1);
    #2; rst = 1'b1; #1;
    check_regs("rst_async", 1'b0, 2'b00, 1'b0);
    check("rst_async.rise_cnt", {30'd0, rise_cnt}, 32'd0);
    check("rst_async.out", {31'd0, out}, 32'd1);
    @(posedge clk); #1;
    check_regs("rst_held", 1'b0, 2'b00, 1'b0);

    clk_run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
